// File: rtl/hour_counter.sv
// ----------------------------------------------------------------------------
// hour_counter
//   Hour stage of the clock datapath. It counts the hour of day (0-23) on
//   rising edges of the minute counter's carry. The hour can also be set by
//   hand with the inc/dec buttons. The value is shown as two BCD digits in
//   24 h or 12 h format, together with an AM/PM flag. A one-cycle hour_done
//   carry is sent to the day stage on a counted midnight rollover.
//
// Ports
//   clk_1s      in   system clock, all state changes on its rising edge
//   rstn        in   asynchronous active-low reset
//   enable      in   minute carry; its rising edge advances the hour
//   set_enable  in   global setting mode, freezes counting
//   set_mode    in   hour field selected for setting
//   inc / dec   in   setting buttons (levels), act on rising edges
//   mode_12h    in   display format, 0 = 24 h, 1 = 12 h
//   hour_tens   out  BCD tens digit of the displayed hour
//   hour_units  out  BCD units digit of the displayed hour
//   pm          out  1 when the internal hour is 12-23
//   hour_done   out  registered one-cycle pulse on counted 23 -> 0
// ----------------------------------------------------------------------------
module hour_counter #(
    parameter int RESET_HOUR = 0
) (
    input  logic       clk_1s,
    input  logic       rstn,
    input  logic       enable,
    input  logic       set_enable,
    input  logic       set_mode,
    input  logic       inc,
    input  logic       dec,
    input  logic       mode_12h,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_units,
    output logic       pm,
    output logic       hour_done
);

    localparam logic [4:0] RST_HOUR = 5'(RESET_HOUR);

    logic [4:0] r_hour;
    logic       r_enable_q;
    logic       r_inc_q;
    logic       r_dec_q;
    logic       r_hour_done;

    logic       w_enable_rise;
    logic       w_inc_rise;
    logic       w_dec_rise;
    logic [4:0] w_hour_next;
    logic       w_done_next;
    logic [4:0] w_disp_hour;
    logic [7:0] w_bcd;

    // Map 0-23 onto the 12 h dial: 0 -> 12, 13 -> 1, and so on.
    function automatic logic [4:0] to_12h(input logic [4:0] h);
        logic [4:0] m;
        m = (h >= 5'd12) ? h - 5'd12 : h;
        return (m == 5'd0) ? 5'd12 : m;
    endfunction

    // Binary 0-23 to two BCD digits, using compare/subtract only.
    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        if (v >= 5'd20) begin
            tens  = 4'd2;
            units = 4'(v - 5'd20);
        end else if (v >= 5'd10) begin
            tens  = 4'd1;
            units = 4'(v - 5'd10);
        end else begin
            tens  = 4'd0;
            units = 4'(v);
        end
        return {tens, units};
    endfunction

    assign w_enable_rise = enable & ~r_enable_q;
    assign w_inc_rise    = inc    & ~r_inc_q;
    assign w_dec_rise    = dec    & ~r_dec_q;

    always_comb begin
        w_hour_next = r_hour;
        w_done_next = 1'b0;
        if (!set_enable) begin
            if (w_enable_rise) begin
                if (r_hour == 5'd23) begin
                    w_hour_next = 5'd0;
                    w_done_next = 1'b1;
                end else begin
                    w_hour_next = r_hour + 5'd1;
                end
            end
        end else if (set_mode) begin
            // Setting never raises hour_done. Pressing both buttons at once
            // leaves the hour unchanged.
            if (w_inc_rise && !w_dec_rise) begin
                w_hour_next = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
            end else if (w_dec_rise && !w_inc_rise) begin
                w_hour_next = (r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1;
            end
        end
    end

    // Edge registers reset to 1 so that an input held high across reset
    // release is not seen as a fresh edge.
    always_ff @(posedge clk_1s or negedge rstn) begin
        if (!rstn) begin
            r_hour      <= RST_HOUR;
            r_hour_done <= 1'b0;
            r_enable_q  <= 1'b1;
            r_inc_q     <= 1'b1;
            r_dec_q     <= 1'b1;
        end else begin
            r_hour      <= w_hour_next;
            r_hour_done <= w_done_next;
            r_enable_q  <= enable;
            r_inc_q     <= inc;
            r_dec_q     <= dec;
        end
    end

    assign w_disp_hour = mode_12h ? to_12h(r_hour) : r_hour;
    assign w_bcd       = to_bcd(w_disp_hour);
    assign hour_tens   = w_bcd[7:4];
    assign hour_units  = w_bcd[3:0];
    assign pm          = (r_hour >= 5'd12);
    assign hour_done   = r_hour_done;

endmodule
